// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch producer.
// Fetch FSM states, reset PC default, instruction width and PC increment.
package ifu_fetch_pkg;

    localparam int          INST_W           = 32;
    localparam int          PC_STEP          = 4;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_reg.sv
// Generic enabled register with asynchronous active-low reset.
// Holds the PC and the payload presented toward IF/ID.
module ifu_fetch_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// IF-stage fetch producer: one outstanding imem request, redirect/kill handling,
// and a registered {pc, inst} hand-off toward the IF/ID pipeline register.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data
);

    fetch_state_e      state_q, state_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              out_valid_d;
    logic              out_load;
    logic [ADDR_W-1:0] redirect_tgt;
    logic [1:0]        unused_redirect_lsb;

    // Instructions are word aligned, so the low target bits are dropped.
    assign redirect_tgt        = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsb = redirect_pc[1:0];
    assign imem_req_addr       = pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= REQ;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        kill_d         = kill_q;
        pc_d           = pc_q;
        out_valid_d    = out_valid;
        out_load       = 1'b0;
        imem_req_valid = 1'b0;

        unique case (state_q)
            REQ: begin
                imem_req_valid = 1'b1;
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (imem_req_ready) begin
                    // A request accepted alongside a redirect is for the old PC.
                    state_d = WAIT;
                    kill_d  = redirect_valid;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                        if (redirect_valid) begin
                            pc_d = redirect_tgt;
                        end
                    end else begin
                        out_load    = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_d   = redirect_tgt;
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    out_valid_d = 1'b0;
                    pc_d        = redirect_tgt;
                    state_d     = REQ;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    pc_d        = pc_q + ADDR_W'(PC_STEP);
                    state_d     = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    ifu_fetch_reg #(.W(ADDR_W), .RST_VAL(PC_RESET)) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (pc_d),
        .q   (pc_q)
    );

    ifu_fetch_reg #(.W(1), .RST_VAL(1'b0)) u_out_valid_reg (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (out_valid_d),
        .q   (out_valid)
    );

    ifu_fetch_reg #(.W(ADDR_W), .RST_VAL('0)) u_out_pc_reg (
        .clk (clk),
        .rst (rst),
        .en  (out_load),
        .d   (pc_q),
        .q   (out_pc)
    );

    ifu_fetch_reg #(.W(INST_W), .RST_VAL('0)) u_out_inst_reg (
        .clk (clk),
        .rst (rst),
        .en  (out_load),
        .d   (imem_rsp_data),
        .q   (out_inst)
    );

`ifndef SYNTHESIS
    rsp_only_in_wait: assert property (
        @(posedge clk) disable iff (!rst) imem_rsp_valid |-> (state_q == WAIT)
    ) else $error("imem response arrived outside WAIT");
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a behavioural instruction memory with
// configurable latency, and a scoreboard of expected {pc, inst} presentations.
module tb_ifu_fetch;

    localparam logic [31:0] PC_RST = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    int   pres_cyc[$];

    logic        mem_ready_en = 1'b0;
    int          mem_lat      = 1;
    int          pend_cnt     = 0;
    logic [31:0] pend_addr    = '0;
    logic        prev_ov      = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hC0DE_1234;
    endfunction

    // Memory model: decides acceptance and delivers responses on the falling edge.
    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            if (rst !== 1'b1) begin
                pend_cnt       = 0;
                imem_req_ready = 1'b0;
            end else begin
                if (pend_cnt > 0) begin
                    pend_cnt = pend_cnt - 1;
                    if (pend_cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = mem_word(pend_addr);
                    end
                end
                imem_req_ready = mem_ready_en && (pend_cnt == 0);
                if (imem_req_valid === 1'b1 && imem_req_ready) begin
                    pend_addr = imem_req_addr;
                    pend_cnt  = mem_lat;
                end
            end
        end
    end

    // Scoreboard: every new presentation on out_* must match the next expected fetch.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && !prev_ov) begin
                pres_cyc.push_back(cyc);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got pc=%h inst=%h, required no presentation", out_pc, out_inst);
                end else begin
                    e = exp_q.pop_front();
                    if (out_pc !== e.pc || out_inst !== e.inst) begin
                        n_err++;
                        $display("FAIL presented_payload: got pc=%h inst=%h, required pc=%h inst=%h",
                                 out_pc, out_inst, e.pc, e.inst);
                    end
                end
            end
            prev_ov = (out_valid === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = mem_word(pc);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (exp_q.size() == 0) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d fetches outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        repeat (2) step();
        n_cmp++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b pc=%h inst=%h, required v=0 pc=0 inst=0",
                     out_valid, out_pc, out_inst);
        end
        rst = 1'b1;
        // Memory not ready: the request must stay asserted at the reset PC.
        repeat (3) begin
            step();
            n_cmp++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== PC_RST) begin
                n_err++;
                $display("FAIL reset_request: got valid=%b addr=%h, required valid=1 addr=%h",
                         imem_req_valid, imem_req_addr, PC_RST);
            end
        end
    endtask

    task automatic test_sequential();
        pres_cyc.delete();
        expect_fetch(32'h8000_0000);
        expect_fetch(32'h8000_0004);
        expect_fetch(32'h8000_0008);
        mem_ready_en = 1'b1;
        wait_drain(40);
        out_ready = 1'b0;
        n_cmp++;
        if (pres_cyc.size() != 3) begin
            n_err++;
            $display("FAIL seq_count: got %0d presentations, required 3", pres_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (pres_cyc[i] - pres_cyc[i-1] != 3) begin
                    n_err++;
                    $display("FAIL seq_spacing: got %0d cycles, required 3", pres_cyc[i] - pres_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_hold_stall();
        repeat (5) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== 32'h8000_0008 ||
                out_inst !== mem_word(32'h8000_0008) || imem_req_valid !== 1'b0) begin
                n_err++;
                $display("FAIL hold_stable: got v=%b pc=%h inst=%h req=%b, required v=1 pc=80000008 inst=%h req=0",
                         out_valid, out_pc, out_inst, imem_req_valid, mem_word(32'h8000_0008));
            end
        end
        expect_fetch(32'h8000_000C);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        wait_drain(20);
    endtask

    task automatic test_redirect_wait();
        mem_lat = 2;
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0010) begin
            n_err++;
            $display("FAIL rw_first_req: got valid=%b addr=%h, required valid=1 addr=80000010",
                     imem_req_valid, imem_req_addr);
        end
        step();
        expect_fetch(32'h8000_0100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        n_cmp++;
        if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rw_in_wait: got req=%b v=%b, required req=0 v=0", imem_req_valid, out_valid);
        end
        step();
        mem_lat = 1;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rw_refetch: got req=%b addr=%h v=%b, required req=1 addr=80000100 v=0",
                     imem_req_valid, imem_req_addr, out_valid);
        end
        wait_drain(20);
    endtask

    task automatic test_redirect_hold();
        expect_fetch(32'h8000_0100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
            n_err++;
            $display("FAIL rh_flush: got v=%b req=%b addr=%h, required v=0 req=1 addr=80000100",
                     out_valid, imem_req_valid, imem_req_addr);
        end
        wait_drain(20);
    endtask

    task automatic test_wrap();
        expect_fetch(32'hFFFF_FFFC);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        wait_drain(20);
        expect_fetch(32'h0000_0000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL wrap_addr: got req=%b addr=%h, required req=1 addr=00000000",
                     imem_req_valid, imem_req_addr);
        end
        wait_drain(20);
        expect_fetch(32'h8000_0100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        step();
        redirect_valid = 1'b0;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
            n_err++;
            $display("FAIL align_addr: got req=%b addr=%h, required req=1 addr=80000100",
                     imem_req_valid, imem_req_addr);
        end
        wait_drain(20);
    endtask

    task automatic test_reset_mid();
        mem_lat = 3;
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rm_in_wait: got req=%b, required req=0", imem_req_valid);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0 ||
            imem_req_valid !== 1'b1 || imem_req_addr !== PC_RST) begin
            n_err++;
            $display("FAIL rm_async: got v=%b pc=%h inst=%h req=%b addr=%h, required v=0 pc=0 inst=0 req=1 addr=%h",
                     out_valid, out_pc, out_inst, imem_req_valid, imem_req_addr, PC_RST);
        end
        repeat (2) step();
        rst     = 1'b1;
        mem_lat = 1;
        expect_fetch(PC_RST);
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== PC_RST) begin
            n_err++;
            $display("FAIL rm_release: got req=%b addr=%h, required req=1 addr=%h",
                     imem_req_valid, imem_req_addr, PC_RST);
        end
        wait_drain(20);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_reset_mid();
        repeat (5) step();
        n_cmp++;
        if (exp_q.size() != 0 || out_valid !== 1'b1 || out_pc !== PC_RST) begin
            n_err++;
            $display("FAIL final_state: got pending=%0d v=%b pc=%h, required pending=0 v=1 pc=%h",
                     exp_q.size(), out_valid, out_pc, PC_RST);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
